// File: rtl/layer_sequencer.sv
// Two-layer MLP inference sequencer: steps neuron/row counters, drives SRAM addresses and MAC/write-back strobes.
// Optional busy-cycle counter on perf_cycles is built only when LAYER_SEQ_PERF_EN is defined.
module layer_sequencer #(
  parameter int NUM_BANKS = 64,
  parameter int L1_IN     = 784,
  parameter int L1_OUT    = 200,
  parameter int L2_OUT    = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stall,
  output logic                 busy,
  output logic                 done,
  output logic                 layer,
  output logic [3:0]           row,
  output logic [11:0]          w_addr_hi,
  output logic [11:0]          w_addr_lo,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic                 mac_en,
  output logic                 mac_clear,
  output logic                 wb_en,
  output logic [7:0]           wb_addr,
  output logic [31:0]          perf_cycles,
  output logic [1:0]           dbg_state
);

  localparam int L1_ROWS = (L1_IN + NUM_BANKS - 1) / NUM_BANKS;
  localparam int L2_ROWS = (L1_OUT + NUM_BANKS - 1) / NUM_BANKS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        layer_q, layer_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  neuron_q, neuron_d;

  logic [3:0]  last_row;
  logic [7:0]  last_neuron;
  logic [11:0] rows_hi;
  logic [11:0] rows_lo;
  int          in_len;
  logic        active;

  always_comb begin
    last_row    = layer_q ? 4'(L2_ROWS - 1) : 4'(L1_ROWS - 1);
    last_neuron = layer_q ? 8'(L2_OUT - 1)  : 8'(L1_OUT - 1);
    rows_hi     = layer_q ? 12'(L2_ROWS)    : 12'(L1_ROWS);
    rows_lo     = rows_hi - 12'd1;
    in_len      = layer_q ? L1_OUT : L1_IN;
    active      = (state_q == S_MAC) || (state_q == S_WB);
  end

  // stall freezes every register, including acceptance of start in IDLE.
  // start has no ready: it is honoured only in IDLE with stall low, dropped otherwise.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    row_d    = row_q;
    neuron_d = neuron_q;
    if (!stall) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_MAC;
            layer_d  = 1'b0;
            row_d    = 4'd0;
            neuron_d = 8'd0;
          end
        end
        S_MAC: begin
          if (row_q == last_row) state_d = S_WB;
          else                   row_d   = row_q + 4'd1;
        end
        S_WB: begin
          row_d = 4'd0;
          if (neuron_q != last_neuron) begin
            state_d  = S_MAC;
            neuron_d = neuron_q + 8'd1;
          end else if (!layer_q) begin
            state_d  = S_MAC;
            layer_d  = 1'b1;
            neuron_d = 8'd0;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d  = S_IDLE;
          layer_d  = 1'b0;
          row_d    = 4'd0;
          neuron_d = 8'd0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      layer_q  <= 1'b0;
      row_q    <= 4'd0;
      neuron_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      row_q    <= row_d;
      neuron_q <= neuron_d;
    end
  end

  // Outputs decode straight from registers so reset clears them without waiting for a clock.
  always_comb begin
    busy      = active;
    done      = (state_q == S_DONE);
    layer     = layer_q;
    mac_en    = (state_q == S_MAC) && !stall;
    mac_clear = (state_q == S_MAC) && !stall && (row_q == 4'd0);
    wb_en     = (state_q == S_WB) && !stall;
    row       = active ? row_q : 4'd0;
    wb_addr   = active ? neuron_q : 8'd0;
    w_addr_hi = active ? (({4'd0, neuron_q} * rows_hi) + {8'd0, row_q}) : 12'd0;
    w_addr_lo = active ? (({4'd0, neuron_q} * rows_lo) + {8'd0, row_q}) : 12'd0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      bank_en[i] = active && ((int'(row_q) * NUM_BANKS + i) < in_len);
    end
    dbg_state = state_q;
  end

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start && !stall) perf_d = 32'd0;
    else if (active)                            perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_q <= 32'd0;
    else          perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: cycle-indexed vector table, write-back scoreboard,
// stall / restart / mid-run reset sequences.
module tb_layer_sequencer;
  localparam int NB = 64;
  localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          busy, done, layer, mac_en, mac_clear, wb_en;
  logic [3:0]    row;
  logic [11:0]   w_addr_hi, w_addr_lo;
  logic [NB-1:0] bank_en;
  logic [7:0]    wb_addr;
  logic [31:0]   perf_cycles;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int wb_seen = 0;
  logic [7:0] exp_q[$];

  layer_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
    .busy(busy), .done(done), .layer(layer), .row(row),
    .w_addr_hi(w_addr_hi), .w_addr_lo(w_addr_lo), .bank_en(bank_en),
    .mac_en(mac_en), .mac_clear(mac_clear), .wb_en(wb_en), .wb_addr(wb_addr),
    .perf_cycles(perf_cycles), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          chk_layer;
    logic        layer;
    bit          chk_addr;
    logic [3:0]  row;
    logic [11:0] hi;
    logic [11:0] lo;
    logic [63:0] bank;
    logic        mac_en;
    logic        mac_clear;
    logic        wb_en;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mk(input int cyc, input bit cl, input logic ly, input bit ca,
                              input logic [3:0] r, input logic [11:0] h, input logic [11:0] l,
                              input logic [63:0] b, input logic me, input logic mc, input logic we);
    vec_t v;
    v.cyc = cyc; v.chk_layer = cl; v.layer = ly; v.chk_addr = ca;
    v.row = r; v.hi = h; v.lo = l; v.bank = b;
    v.mac_en = me; v.mac_clear = mc; v.wb_en = we;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_layer"}, 64'(layer), 64'd0);
    chk({tag, "_row"},   64'(row), 64'd0);
    chk({tag, "_hi"},    64'(w_addr_hi), 64'd0);
    chk({tag, "_lo"},    64'(w_addr_lo), 64'd0);
    chk({tag, "_bank"},  64'(bank_en), 64'd0);
    chk({tag, "_mac"},   64'(mac_en), 64'd0);
    chk({tag, "_clr"},   64'(mac_clear), 64'd0);
    chk({tag, "_wb"},    64'(wb_en), 64'd0);
    chk({tag, "_wbad"},  64'(wb_addr), 64'd0);
    chk({tag, "_perf"},  64'(perf_cycles), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // One inference from a start pulse in cycle 0. Cycle c is the c-th clock after start is sampled.
  task automatic do_run(input int stall_at, input int nstall, input int restart_at,
                        input int abort_at, input int done_cyc);
    logic [31:0] exp_perf;
`ifdef LAYER_SEQ_PERF_EN
    exp_perf = 32'(done_cyc - 1);
`else
    exp_perf = 32'd0;
`endif
    wb_seen = 0;
    exp_q.delete();
    @(negedge clk);
    start = 1'b1;
    stall = 1'b0;
    for (int n = 0; n < 200; n++) exp_q.push_back(8'(n));
    for (int n = 0; n < 10; n++)  exp_q.push_back(8'(n));
    for (int c = 1; c <= done_cyc + 2; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      stall = (c >= stall_at) && (c < stall_at + nstall);
      if (c == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        return;
      end
      #1;
      chk("busy", 64'(busy), 64'(c < done_cyc));
      chk("done", 64'(done), 64'(c == done_cyc));
      if (c == done_cyc || c == done_cyc + 1) chk("perf", 64'(perf_cycles), 64'(exp_perf));
      if (stall) begin
        chk("stall_row", 64'(row), 64'(stall_at - 1));
        chk("stall_mac", 64'(mac_en), 64'd0);
        chk("stall_clr", 64'(mac_clear), 64'd0);
        chk("stall_wb",  64'(wb_en), 64'd0);
      end
      if (nstall == 0) begin
        for (int k = 0; k < NV; k++) begin
          if (vecs[k].cyc == c) begin
            chk($sformatf("v%0d_mac", k), 64'(mac_en), 64'(vecs[k].mac_en));
            chk($sformatf("v%0d_clr", k), 64'(mac_clear), 64'(vecs[k].mac_clear));
            chk($sformatf("v%0d_wb", k),  64'(wb_en), 64'(vecs[k].wb_en));
            if (vecs[k].chk_layer) chk($sformatf("v%0d_layer", k), 64'(layer), 64'(vecs[k].layer));
            if (vecs[k].chk_addr) begin
              chk($sformatf("v%0d_row", k),  64'(row), 64'(vecs[k].row));
              chk($sformatf("v%0d_hi", k),   64'(w_addr_hi), 64'(vecs[k].hi));
              chk($sformatf("v%0d_lo", k),   64'(w_addr_lo), 64'(vecs[k].lo));
              chk($sformatf("v%0d_bank", k), 64'(bank_en), vecs[k].bank);
            end
          end
        end
      end
      if (wb_en) begin
        wb_seen++;
        if (exp_q.size() == 0) chk("wb_extra", 64'(wb_addr), 64'hFFFF);
        else chk("wb_addr", 64'(wb_addr), 64'(exp_q.pop_front()));
      end
    end
    start = 1'b0;
    stall = 1'b0;
    chk("wb_count", 64'(wb_seen), 64'd210);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vecs[0]  = mk(1,    1, 1'b0, 1, 4'd0,  12'd0,  12'd0,  ALL,      1, 1, 0);
    vecs[1]  = mk(2,    1, 1'b0, 1, 4'd1,  12'd1,  12'd1,  ALL,      1, 0, 0);
    vecs[2]  = mk(13,   1, 1'b0, 1, 4'd12, 12'd12, 12'd12, 64'hFFFF, 1, 0, 0);
    vecs[3]  = mk(14,   1, 1'b0, 0, 4'd0,  12'd0,  12'd0,  64'd0,    0, 0, 1);
    vecs[4]  = mk(15,   1, 1'b0, 1, 4'd0,  12'd13, 12'd12, ALL,      1, 1, 0);
    vecs[5]  = mk(83,   1, 1'b0, 1, 4'd12, 12'd77, 12'd72, 64'hFFFF, 1, 0, 0);
    vecs[6]  = mk(101,  1, 1'b0, 1, 4'd2,  12'd93, 12'd86, ALL,      1, 0, 0);
    vecs[7]  = mk(2800, 1, 1'b0, 0, 4'd0,  12'd0,  12'd0,  64'd0,    0, 0, 1);
    vecs[8]  = mk(2801, 1, 1'b1, 1, 4'd0,  12'd0,  12'd0,  ALL,      1, 1, 0);
    vecs[9]  = mk(2814, 1, 1'b1, 1, 4'd3,  12'd11, 12'd9,  64'hFF,   1, 0, 0);
    vecs[10] = mk(2849, 1, 1'b1, 1, 4'd3,  12'd39, 12'd30, 64'hFF,   1, 0, 0);
    vecs[11] = mk(2850, 1, 1'b1, 0, 4'd0,  12'd0,  12'd0,  64'd0,    0, 0, 1);
    vecs[12] = mk(2851, 0, 1'b0, 1, 4'd0,  12'd0,  12'd0,  64'd0,    0, 0, 0);
    vecs[13] = mk(2852, 0, 1'b0, 1, 4'd0,  12'd0,  12'd0,  64'd0,    0, 0, 0);

    // reset
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("rst");
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk_all_zero("idle");

    do_run(0, 0, 100, 0, 2851);   // nominal run with a stray start at cycle 100
    do_run(5, 3, 0, 0, 2854);     // stall three cycles at L1 neuron 0 row 4
    do_run(0, 0, 0, 1500, 2851);  // reset asserted mid-run
    #1;
    chk_all_zero("post_abort");
    do_run(0, 0, 0, 0, 2851);     // fresh run after reset

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_BANKS, default 64, number of parallel SRAM/MAC lanes.
REQ-002 Parameter L1_IN, default 784, layer-1 input length.
REQ-003 Parameter L1_OUT, default 200, layer-1 neuron count (equals layer-2 input length).
REQ-004 Parameter L2_OUT, default 10, layer-2 neuron count.
REQ-005 Port clk  in  1  single clock, all logic on rising edge.
REQ-006 Port reset_n  in  1  reset, asynchronous, active-low.
REQ-007 Port start  in  1  one-cycle request to run a full two-layer inference.
REQ-008 Port stall  in  1  freeze all state and counters this cycle (SRAM port busy).
REQ-009 Port busy  out  1  high from first MAC cycle until the last write-back completes.
REQ-010 Port done  out  1  one-cycle pulse after layer-2 completes.
REQ-011 Port layer  out  1  0 = layer 1, 1 = layer 2.
REQ-012 Port row  out  4  row index j, driven as input/activation SRAM address.
REQ-013 Port w_addr_hi  out  12  weight address for banks holding the extra row: neuron*(rows)+row.
REQ-014 Port w_addr_lo  out  12  weight address for remaining banks: neuron*(rows-1)+row.
REQ-015 Port bank_en  out  NUM_BANKS  lane i valid when 64*row+i < current layer input length.
REQ-016 Port mac_en  out  1  MAC lanes accumulate this cycle.
REQ-017 Port mac_clear  out  1  MAC loads (not adds) this cycle; first row of each neuron.
REQ-018 Port wb_en  out  1  write reduced neuron result this cycle.
REQ-019 Port wb_addr  out  8  neuron index being written back.
REQ-020 Port perf_cycles  out  32  busy-cycle count (see Configuration).

Function
REQ-021 FSM states IDLE, MAC, WB, DONE; layer register selects L1/L2 limits.
REQ-022 IDLE: start=1 -> MAC next cycle, layer=0, neuron=0, row=0; start ignored outside IDLE.
REQ-023 Rows per neuron: ceil(input/NUM_BANKS) = 13 (layer 1), 4 (layer 2); extra-row banks i<16 (L1), i<8 (L2).
REQ-024 MAC: mac_en=1, bank_en per REQ-015, mac_clear=1 only at row 0; row increments each unstalled cycle; after last row -> WB.
REQ-025 WB: one cycle, wb_en=1, wb_addr=neuron; then neuron<limit-1 -> MAC row 0 neuron+1; else layer 0 -> MAC layer 1 neuron 0; else -> DONE.
REQ-026 DONE: done=1 one cycle, busy=0, -> IDLE.
REQ-027 Unstalled timing: start at cycle 0; L1 cycles 1..2800 (200x(13+1)); L2 cycles 2801..2850 (10x(4+1)); done at cycle 2851.
REQ-028 stall=1: all registers hold; mac_en, wb_en, mac_clear forced 0; other outputs hold value.
REQ-029 Address outputs, bank_en, wb_addr are 0 when mac_en and wb_en are both 0 in IDLE/DONE.
REQ-030 w_addr arithmetic unsigned, no wrap for default parameters (max 2599).

Reset
REQ-031 reset_n low: state=IDLE, layer, row, neuron, all outputs 0 immediately, including mid-run.
REQ-032 After reset release, a new start begins at layer 0 neuron 0; no partial-run resumption.

Configuration
REQ-033 Macro LAYER_SEQ_PERF_EN defined: perf_cycles clears on accepted start, increments every busy cycle (stalled included), holds after done.
REQ-034 Macro LAYER_SEQ_PERF_EN undefined: counter not built, perf_cycles tied to 0.

Verification
REQ-035 Reset, start at cycle 0, no stall -> done pulse at cycle 2851, busy high cycles 1..2850, 210 wb_en pulses with wb_addr 0..199 then 0..9.
REQ-036 L1 neuron 5 row 12 -> w_addr_hi=77, w_addr_lo=72, bank_en=0x000000000000FFFF; L2 neuron 2 row 3 -> w_addr_hi=11, bank_en=0x00000000000000FF.
REQ-037 stall high 3 cycles during L1 neuron 0 row 4 -> row holds at 4, mac_en 0, done at cycle 2854; with macro, perf_cycles=2853.
REQ-038 start pulsed again at cycle 100 -> ignored, sequence unchanged.
REQ-039 reset_n low at cycle 1500 -> all outputs 0 same cycle; restart -> run completes as REQ-035.
